// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stage enables/flushes for load-use, MEM branch and memory waits.
// Optional watchdog and ERR state: define PIPE_HAZARD_TIMEOUT_EN.
module pipe_hazard_ctrl #(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic [4:0]       idex_rt,
    input  logic             idex_memrd,
    input  logic             exmem_br,
    input  logic             exmem_zr,
    input  logic             exmem_memrd,
    input  logic             exmem_memwr,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             pc_sel_br,
    output logic             err_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 2");
    end

    state_t           r_state;
    state_t           w_next;
    logic             w_memop;
    logic             w_take;
    logic             w_lu;
    logic             w_adv;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_to_hit;

    assign w_memop = exmem_memrd | exmem_memwr;
    assign w_take  = exmem_br & exmem_zr;
    assign w_lu    = idex_memrd && (idex_rt != 5'd0) &&
                     ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

`ifdef PIPE_HAZARD_TIMEOUT_EN
    localparam int WC_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT_CYC - 1);

    logic [WC_W-1:0] r_wait_cnt;
    logic            r_err;

    assign w_to_hit    = (r_wait_cnt == WC_LAST);
    assign err_timeout = r_err;

    // Watchdog: count un-acked MEM_WAIT cycles, restart on each new wait.
    always_ff @(posedge clk) begin
        if (!rst)
            r_wait_cnt <= '0;
        else if (r_state == RUN)
            r_wait_cnt <= '0;
        else if (r_state == MEM_WAIT && !mem_ack)
            r_wait_cnt <= r_wait_cnt + WC_W'(1);
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst)
            r_err <= 1'b0;
        else if (w_next == ERR)
            r_err <= 1'b1;
    end
`else
    assign w_to_hit    = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst)
            r_state <= RUN;
        else
            r_state <= w_next;
    end

    // Next state and per-stage controls; branch flush beats load-use stall.
    always_comb begin
        w_next      = r_state;
        w_adv       = 1'b0;
        mem_req     = 1'b0;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        pc_sel_br   = 1'b0;
        unique case (r_state)
            RUN: begin
                mem_req = w_memop;
                if (w_memop && !mem_ack)
                    w_next = MEM_WAIT;
                else
                    w_adv = 1'b1;
            end
            MEM_WAIT: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    w_adv  = 1'b1;
                    w_next = RUN;
                end else if (w_to_hit) begin
                    w_next = ERR;
                end
            end
            ERR: ;
            default: w_next = RUN;
        endcase
        if (w_adv) begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            if (w_take) begin
                pc_sel_br   = 1'b1;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
            end else if (w_lu) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
        end
        if (!rst) begin
            mem_req     = 1'b0;
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            ifid_flush  = 1'b0;
            idex_flush  = 1'b0;
            exmem_flush = 1'b0;
            pc_sel_br   = 1'b0;
        end
    end

    // Saturating count of cycles where the PC is held.
    always_ff @(posedge clk) begin
        if (!rst)
            r_stall_cnt <= '0;
        else if (!pc_en && r_stall_cnt != '1)
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end

    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of pipe_hazard_ctrl.
// Timeout section depends on PIPE_HAZARD_TIMEOUT_EN.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] ifid_rs, ifid_rt, idex_rt;
    logic       idex_memrd, exmem_br, exmem_zr;
    logic       exmem_memrd, exmem_memwr, mem_ack;
    logic       mem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_flush, idex_flush, exmem_flush, pc_sel_br;
    logic       err_timeout;
    logic [3:0] stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    pipe_hazard_ctrl #(.TIMEOUT_CYC(16), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .idex_rt(idex_rt),
        .idex_memrd(idex_memrd), .exmem_br(exmem_br), .exmem_zr(exmem_zr),
        .exmem_memrd(exmem_memrd), .exmem_memwr(exmem_memwr),
        .mem_ack(mem_ack), .mem_req(mem_req),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .pc_sel_br(pc_sel_br),
        .err_timeout(err_timeout), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    wire [4:0] en = {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
    wire [2:0] fl = {ifid_flush, idex_flush, exmem_flush};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic clr;
        ifid_rs = 0; ifid_rt = 0; idex_rt = 0; idex_memrd = 0;
        exmem_br = 0; exmem_zr = 0; exmem_memrd = 0; exmem_memwr = 0;
        mem_ack = 0;
    endtask

    task automatic do_reset;
        rst = 0;
        tick();
        rst = 1;
        settle();
    endtask

    initial begin
        clr();
        rst = 0;
        exmem_memrd = 1; exmem_br = 1; exmem_zr = 1;
        settle();
        chk("rst_en", en, 5'b00000);
        chk("rst_req", mem_req, 0);
        chk("rst_fl", fl, 3'b000);
        chk("rst_sel", pc_sel_br, 0);
        tick(); tick(); tick();
        chk("rst_cnt", stall_cnt, 0);
        chk("rst_err", err_timeout, 0);
        clr();
        rst = 1;
        settle();
        chk("run_en", en, 5'b11111);
        chk("run_fl", fl, 3'b000);
        chk("run_req", mem_req, 0);

        // load-use via rs
        idex_memrd = 1; idex_rt = 5; ifid_rs = 5;
        settle();
        chk("lu_rs_en", en, 5'b00111);
        chk("lu_rs_fl", fl, 3'b010);
        tick();
        chk("lu_cnt1", stall_cnt, 1);
        idex_memrd = 0;
        settle();
        chk("lu_clear_en", en, 5'b11111);
        // rt == 0 never stalls
        idex_memrd = 1; idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
        settle();
        chk("lu_r0_en", en, 5'b11111);
        // load-use via rt
        idex_rt = 7; ifid_rt = 7; ifid_rs = 3;
        settle();
        chk("lu_rt_en", en, 5'b00111);
        tick();
        chk("lu_cnt2", stall_cnt, 2);
        clr();

        // taken branch beats load-use
        idex_memrd = 1; idex_rt = 5; ifid_rs = 5;
        exmem_br = 1; exmem_zr = 1;
        settle();
        chk("br_en", en, 5'b11111);
        chk("br_fl", fl, 3'b111);
        chk("br_sel", pc_sel_br, 1);
        idex_memrd = 0; exmem_zr = 0;
        settle();
        chk("br_nt_fl", fl, 3'b000);
        chk("br_nt_sel", pc_sel_br, 0);
        chk("br_nt_en", en, 5'b11111);
        clr();

        // memory wait, ack on 4th request cycle
        do_reset();
        chk("mw_cnt0", stall_cnt, 0);
        exmem_memrd = 1;
        settle();
        chk("mw1_req", mem_req, 1);
        chk("mw1_en", en, 5'b00000);
        tick();
        exmem_br = 1; exmem_zr = 1;
        settle();
        chk("mw2_req", mem_req, 1);
        chk("mw2_en", en, 5'b00000);
        chk("mw2_sel", pc_sel_br, 0);
        chk("mw2_fl", fl, 3'b000);
        tick();
        exmem_br = 0; exmem_zr = 0;
        settle();
        chk("mw3_en", en, 5'b00000);
        tick();
        mem_ack = 1;
        settle();
        chk("mw4_req", mem_req, 1);
        chk("mw4_en", en, 5'b11111);
        tick();
        exmem_memrd = 0; mem_ack = 0;
        settle();
        chk("mw_after_en", en, 5'b11111);
        chk("mw_after_req", mem_req, 0);
        chk("mw_cnt3", stall_cnt, 3);

        // zero-wait access
        exmem_memwr = 1; mem_ack = 1;
        settle();
        chk("zw_req", mem_req, 1);
        chk("zw_en", en, 5'b11111);
        tick();
        chk("zw_cnt", stall_cnt, 3);
        clr();

        // saturation via held load-use
        do_reset();
        idex_memrd = 1; idex_rt = 9; ifid_rt = 9;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_cnt", stall_cnt, 15);
        clr();

`ifdef PIPE_HAZARD_TIMEOUT_EN
        // ack in the last allowed cycle wins
        do_reset();
        exmem_memwr = 1;
        for (int i = 0; i < 16; i++) tick();
        mem_ack = 1;
        settle();
        chk("aw_en", en, 5'b11111);
        chk("aw_err", err_timeout, 0);
        tick();
        chk("aw_err2", err_timeout, 0);
        clr();

        // timeout into ERR
        do_reset();
        exmem_memwr = 1;
        for (int i = 0; i < 16; i++) tick();
        chk("to_pre_err", err_timeout, 0);
        tick();
        chk("to_err", err_timeout, 1);
        chk("to_req", mem_req, 0);
        chk("to_en", en, 5'b00000);
        chk("to_cnt", stall_cnt, 15);
        mem_ack = 1;
        settle();
        chk("to_ack_en", en, 5'b00000);
        tick();
        chk("to_sticky", err_timeout, 1);
        clr();
        rst = 0;
        settle();
        chk("to_rst_req", mem_req, 0);
        tick();
        rst = 1;
        settle();
        chk("to_clr_err", err_timeout, 0);
        chk("to_clr_en", en, 5'b11111);
        chk("to_clr_cnt", stall_cnt, 0);
`else
        // no watchdog: waits indefinitely
        do_reset();
        exmem_memwr = 1;
        for (int i = 0; i < 20; i++) tick();
        chk("nw_err", err_timeout, 0);
        chk("nw_req", mem_req, 1);
        chk("nw_en", en, 5'b00000);
        chk("nw_cnt", stall_cnt, 15);
        mem_ack = 1;
        settle();
        chk("nw_ack_en", en, 5'b11111);
        mem_ack = 0;
        settle();
        chk("nw_hold_en", en, 5'b00000);
`endif

        // reset while waiting returns to RUN
        clr();
        do_reset();
        exmem_memrd = 1;
        tick(); tick();
        chk("rw_req", mem_req, 1);
        rst = 0;
        settle();
        chk("rw_req_drop", mem_req, 0);
        tick();
        rst = 1;
        exmem_memrd = 0;
        settle();
        chk("rw_run_req", mem_req, 0);
        chk("rw_run_en", en, 5'b11111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
